// File: rtl/ppu_result_buf.sv
// Result buffer behind the combinational ppu: a small first-word-fall-through FIFO
// holding {inf, zero, res}, plus saturating debug counts of inf and zero results.
module ppu_result_buf #(
  parameter int unsigned N     = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N-1:0]               in_res,
  input  logic                       in_inf,
  input  logic                       in_zero,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N-1:0]               out_res,
  output logic                       out_inf,
  output logic                       out_zero,
  output logic [$clog2(DEPTH):0]     level,
  input  logic                       clr_cnt,
  output logic [CW-1:0]              inf_cnt,
  output logic [CW-1:0]              zero_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned EW = N + 2;
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  // Handshake flags come only from registered occupancy, never from the peer's inputs.
  assign in_ready  = (level != LW'(DEPTH));
  assign out_valid = (level != LW'(0));
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign out_res  = out_valid ? mem[rd_ptr][N-1:0] : N'(0);
  assign out_inf  = out_valid ? mem[rd_ptr][N+1]   : 1'b0;
  assign out_zero = out_valid ? mem[rd_ptr][N]     : 1'b0;

  // Storage is intentionally not reset; pointers and level define what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_inf, in_zero, in_res};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= AW'(0);
      rd_ptr <= AW'(0);
      level  <= LW'(0);
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      level <= level + LW'(1);
      else if (pop && !push) level <= level - LW'(1);
    end
  end

  // Clear wins over a same-cycle push; counts hold at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inf_cnt  <= CW'(0);
      zero_cnt <= CW'(0);
    end else if (clr_cnt) begin
      inf_cnt  <= CW'(0);
      zero_cnt <= CW'(0);
    end else if (push) begin
      if (in_inf && (inf_cnt != CNT_MAX))   inf_cnt  <= inf_cnt + CW'(1);
      if (in_zero && (zero_cnt != CNT_MAX)) zero_cnt <= zero_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_ppu_result_buf.sv
// Bench for ppu_result_buf: directed and random steps checked against a queue model;
// a second instance with 2-bit counters shares the stimulus to exercise saturation.
module tb_ppu_result_buf;

  localparam int unsigned N     = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic        inf;
    logic        zero;
    logic [31:0] res;
  } ent_t;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_res;
  logic          in_inf;
  logic          in_zero;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_res;
  logic          out_inf;
  logic          out_zero;
  logic [LW-1:0] level;
  logic          clr_cnt;
  logic [15:0]   inf_cnt;
  logic [15:0]   zero_cnt;

  logic          in_ready2;
  logic          out_valid2;
  logic [N-1:0]  out_res2;
  logic          out_inf2;
  logic          out_zero2;
  logic [LW-1:0] level2;
  logic [1:0]    inf_cnt2;
  logic [1:0]    zero_cnt2;

  int checks = 0;
  int errors = 0;

  ent_t q[$];
  int   m_inf, m_zero, m_inf2, m_zero2;

  ppu_result_buf #(.N(N), .DEPTH(DEPTH), .CW(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_res(in_res), .in_inf(in_inf), .in_zero(in_zero),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
    .out_inf(out_inf), .out_zero(out_zero), .level(level),
    .clr_cnt(clr_cnt), .inf_cnt(inf_cnt), .zero_cnt(zero_cnt)
  );

  ppu_result_buf #(.N(N), .DEPTH(DEPTH), .CW(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in_res(in_res), .in_inf(in_inf), .in_zero(in_zero),
    .out_valid(out_valid2), .out_ready(out_ready), .out_res(out_res2),
    .out_inf(out_inf2), .out_zero(out_zero2), .level(level2),
    .clr_cnt(clr_cnt), .inf_cnt(inf_cnt2), .zero_cnt(zero_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    ent_t h;
    h = (q.size() > 0) ? q[0] : '0;
    check({tag, " out_valid"}, 32'(out_valid), 32'(q.size() > 0));
    check({tag, " in_ready"},  32'(in_ready),  32'(q.size() < DEPTH));
    check({tag, " level"},     32'(level),     32'(q.size()));
    check({tag, " out_res"},   out_res,        h.res);
    check({tag, " out_inf"},   32'(out_inf),   32'(h.inf));
    check({tag, " out_zero"},  32'(out_zero),  32'(h.zero));
    check({tag, " inf_cnt"},   32'(inf_cnt),   32'(m_inf));
    check({tag, " zero_cnt"},  32'(zero_cnt),  32'(m_zero));
    check({tag, " level2"},    32'(level2),    32'(q.size()));
    check({tag, " inf_cnt2"},  32'(inf_cnt2),  32'(m_inf2));
    check({tag, " zero_cnt2"}, 32'(zero_cnt2), 32'(m_zero2));
  endtask

  function automatic int sat_add(input int v, input logic b, input int maxv);
    return (b && v < maxv) ? v + 1 : v;
  endfunction

  // One clock of stimulus; the model decides acceptance from its own occupancy.
  task automatic step(input string tag, input logic v, input logic [31:0] r,
                      input logic fi, input logic fz, input logic ordy, input logic clr);
    bit do_push, do_pop;
    ent_t e;
    @(negedge clk);
    in_valid = v; in_res = r; in_inf = fi; in_zero = fz;
    out_ready = ordy; clr_cnt = clr;
    do_push = v && (q.size() < DEPTH);
    do_pop  = ordy && (q.size() > 0);
    @(posedge clk);
    if (do_pop) void'(q.pop_front());
    if (do_push) begin
      e.inf = fi; e.zero = fz; e.res = r;
      q.push_back(e);
    end
    if (clr) begin
      m_inf = 0; m_zero = 0; m_inf2 = 0; m_zero2 = 0;
    end else if (do_push) begin
      m_inf   = sat_add(m_inf, fi, 65535);
      m_zero  = sat_add(m_zero, fz, 65535);
      m_inf2  = sat_add(m_inf2, fi, 3);
      m_zero2 = sat_add(m_zero2, fz, 3);
    end
    #1;
    check_all(tag);
  endtask

  task automatic model_reset();
    q.delete();
    m_inf = 0; m_zero = 0; m_inf2 = 0; m_zero2 = 0;
  endtask

  initial begin
    in_valid = 0; in_res = '0; in_inf = 0; in_zero = 0;
    out_ready = 0; clr_cnt = 0;
    model_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #12;
    check_all("in_reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_all("after_reset");

    // Single push, visible next cycle, then popped.
    step("push1", 1, 32'h40000000, 0, 0, 0, 0);
    step("pop1",  0, 32'h0, 0, 0, 1, 0);

    // Fill past full; fifth value must be rejected.
    for (int i = 1; i <= 5; i++) step("fill", 1, 32'(i), 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step("drain", 0, 32'h0, 0, 0, 1, 0);

    // Streaming at one entry per cycle, pointers wrap many times.
    for (int i = 0; i < 256; i++) step("stream", 1, $urandom, 0, 0, 1, 0);
    step("stream_end", 0, 32'h0, 0, 0, 1, 0);

    // Simultaneous push and pop at level 2.
    step("sp_a", 1, 32'hA, 0, 0, 0, 0);
    step("sp_b", 1, 32'hB, 0, 0, 0, 0);
    step("sp_both", 1, 32'hC, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step("sp_drain", 0, 32'h0, 0, 0, 1, 0);

    // Counters: 3 inf, 2 zero, then clear with a same-cycle inf push.
    for (int i = 0; i < 3; i++) step("cnt_inf", 1, 32'h80000000, 1, 0, 1, 0);
    for (int i = 0; i < 2; i++) step("cnt_zero", 1, 32'h0, 0, 1, 1, 0);
    step("cnt_clr", 1, 32'h80000000, 1, 0, 1, 1);
    for (int i = 0; i < 5; i++) step("cnt_sat", 1, 32'h80000000, 1, 0, 1, 0);
    check("sat_inf_cnt2_is_3", 32'(inf_cnt2), 32'd3);
    for (int i = 0; i < 2; i++) step("cnt_flush", 0, 32'h0, 0, 0, 1, 0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++)
      step("rand", 1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom),
           1'($urandom), 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 31) == 0));

    // Mid-stream asynchronous reset at level 3.
    step("mr_flush", 0, 32'h0, 0, 0, 1, 0);
    step("mr_flush", 0, 32'h0, 0, 0, 1, 0);
    step("mr_flush", 0, 32'h0, 0, 0, 1, 0);
    step("mr_flush", 0, 32'h0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step("mr_fill", 1, 32'(100 + i), 1, 0, 0, 0);
    check("mr_level3", 32'(level), 32'd3);
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("mr_async");
    #1 rst_n = 1'b1;
    step("mr_push", 1, 32'h12345678, 0, 1, 0, 0);
    step("mr_pop",  0, 32'h0, 0, 0, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ppu_result_buf.md
# ppu_result_buf

Result buffer stage directly downstream of the combinational `ppu`. It captures each `ppu` result (`out`, `inf`, `zero`) on a valid/ready handshake and stores it in a small FIFO. It presents results to the consumer (writeback or result-compare logic) with a first-word-fall-through valid/ready interface. It also keeps saturating counts of NaR/infinity and zero results for debug and throughput monitoring.

## Interface
- `N`, 32: posit width in bits (matches `ppu` `N`).
- `DEPTH`, 4: FIFO entries. Must be a power of two, ≥ 2.
- `CW`, 16: width of the statistics counters.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  a `ppu` result is present this cycle.
- `in_ready`  out  1  buffer can accept; equals `!full`.
- `in_res`  in  N  `ppu.out`.
- `in_inf`  in  1  `ppu.inf`.
- `in_zero`  in  1  `ppu.zero`.
- `out_valid`  out  1  head entry is valid; equals `!empty`.
- `out_ready`  in  1  consumer accepts the head entry.
- `out_res`  out  N  head entry result; all-zero when `out_valid` = 0.
- `out_inf`  out  1  head entry inf flag; 0 when empty.
- `out_zero`  out  1  head entry zero flag; 0 when empty.
- `level`  out  $clog2(DEPTH)+1  number of occupied entries.
- `clr_cnt`  in  1  synchronous clear of `inf_cnt` and `zero_cnt`.
- `inf_cnt`  out  CW  pushed entries with `in_inf` = 1, saturating.
- `zero_cnt`  out  CW  pushed entries with `in_zero` = 1, saturating.

## Operation
- Push:
  - A push occurs when `in_valid && in_ready`.
  - `{in_inf, in_zero, in_res}` is written at `wr_ptr`, then `wr_ptr` increments modulo DEPTH.
- Pop:
  - A pop occurs when `out_valid && out_ready`.
  - `rd_ptr` increments modulo DEPTH.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- `level` tracks occupancy:
  - push only: +1
  - pop only: −1
  - both: unchanged
  - neither: unchanged
- `empty` = (`level` == 0); `full` = (`level` == DEPTH).
- Full with `out_ready` = 1: `in_ready` is still 0. There is no push-through-when-full; `in_ready` depends only on `level`, never combinationally on `out_ready`.
- Empty with `in_valid` = 1: the entry is written; `out_valid` does not rise until the next cycle (no bypass).
- Simultaneous push and pop at any level 0 < `level` < DEPTH: both take effect and `level` is unchanged.
- Head outputs are a combinational read of `mem[rd_ptr]`, gated to zero when empty.
- Stored data is unrestricted; the inf/zero flags are passed through unchecked.
- Counters:
  - On a push, `inf_cnt` += `in_inf` and `zero_cnt` += `in_zero`.
  - Each counter holds at 2^CW−1.
  - `clr_cnt` has priority: both counters become 0 and that cycle's push is not counted.
  - `clr_cnt` does not affect FIFO contents.
- Reset (asynchronous, any time, including mid-stream):
  - `wr_ptr`, `rd_ptr`, `level`, `inf_cnt`, `zero_cnt` are all set to 0.
  - Stored entries are discarded.
  - Memory contents are not reset.
- Output values during and after reset:
  - `out_valid` = 0
  - `out_res` = 0, `out_inf` = 0, `out_zero` = 0
  - `in_ready` = 1
  - `level` = 0

## Timing
- Push-to-visible latency is 1 cycle: an entry pushed at edge k gives `out_valid` = 1 with its data after edge k.
- Sustained throughput is 1 entry/cycle when `out_ready` stays high and the buffer is non-full.
- `in_ready`, `out_valid`, `level` and the counters are all registered-state derived; none has a combinational path from `in_valid` or `out_ready`.
- Reset release: the first push is accepted at the first rising edge with `rst_n` = 1.

## Test plan
- Reset then single push:
  - Stimulus: assert `rst_n`; push `in_res` = 32'h40000000 (posit 1.0), `in_inf` = 0, `in_zero` = 0.
  - Required: the following cycle `out_valid` = 1, `out_res` = 32'h40000000, `level` = 1. With `out_ready` = 1 for one cycle: `out_valid` = 0 and `out_res` = 0.
- Fill to full:
  - Stimulus: push 5 values 1..5 with `out_ready` = 0.
  - Required: `in_ready` falls after the 4th push; the 5th is not accepted; `level` = 4. Draining returns exactly 1, 2, 3, 4 in order.
- Streaming:
  - Stimulus: 256 consecutive pushes with `out_ready` held at 1.
  - Required: every cycle after the first, `out_valid` = 1 and `level` = 1; output order matches input order; pointers wrap 64 times without data loss.
- Simultaneous push and pop:
  - Stimulus: at `level` = 2, push and pop in the same cycle.
  - Required: `level` stays 2; the popped entry is the oldest.
- Counters:
  - Stimulus: push 3 entries with `in_inf` = 1 (`in_res` = 32'h80000000) and 2 with `in_zero` = 1.
  - Required: `inf_cnt` = 3 and `zero_cnt` = 2.
  - Then assert `clr_cnt` together with an inf push: both counters read 0.
  - With CW forced to 2: 5 inf pushes give `inf_cnt` = 3 (saturated).
- Mid-stream reset:
  - Stimulus: with `level` = 3, pulse `rst_n` low asynchronously between edges.
  - Required: `out_valid` = 0, `level` = 0 and `in_ready` = 1 immediately; the next push reappears at the head.
